maxpool_window: RTL and testbench

- Streaming max-pool unit for the CNN datapath, with LANES parallel channels.
- Consumes one element per lane per accepted beat and keeps a running ReLU-clamped maximum per lane over a window of WIN beats.
- Emits one pooled result per lane per window.
- Sits between the convolution/accumulate stage and the layer output buffer; successor to the two-input max/ReLU cell.

---
 rtl/cnn_pkg.sv | 19 +
 rtl/maxpool_lane.sv | 86 ++++++++
 rtl/maxpool_window.sv | 121 ++++++++++++
 tb/tb_maxpool_window.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and helpers: default element width, signed
// element type, ReLU clamp and the window beat-index width.
package cnn_pkg;

    localparam int unsigned DEF_DATA_W = 32;

    typedef logic signed [DEF_DATA_W-1:0] data_t;

    // Clamp negative elements to zero
    function automatic data_t relu(input data_t x);
        return x[DEF_DATA_W-1] ? '0 : x;
    endfunction

    // Width of a beat counter that spans 0..win-1, never narrower than 1
    function automatic int unsigned idx_width(input int unsigned win);
        return (win <= 1) ? 1 : $clog2(win);
    endfunction

endpackage

// File: rtl/maxpool_lane.sv
// One pooling lane: ReLU-clamped running maximum over the current window.
// Optional feature macro: MAXPOOL_ARGMAX_EN (tracks the winning beat index).
module maxpool_lane
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              accept_i,
    input  logic [DATA_W-1:0] x_i,
    input  logic [CNT_W-1:0]  cnt_i,
    output logic [DATA_W-1:0] next_o
`ifdef MAXPOOL_ARGMAX_EN
    ,
    output logic [CNT_W-1:0]  next_idx_o
`endif
);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic [DATA_W-1:0] r;
    logic              win;

    // ReLU; the shared helper is used when the width matches the package type
    if (DATA_W == DEF_DATA_W) begin : g_pkg_relu
        assign r = DATA_W'(relu(data_t'(x_i)));
    end else begin : g_local_relu
        assign r = x_i[DATA_W-1] ? '0 : x_i;
    end

    // Strict compare so ties keep the earlier value
    assign win    = r > acc_q;
    assign next_o = win ? r : acc_q;

    // Accumulator next state: restart wins over a normal update
    always_comb begin
        acc_d = acc_q;
        if (start_i) begin
            acc_d = '0;
        end else if (accept_i) begin
            acc_d = next_o;
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

`ifdef MAXPOOL_ARGMAX_EN
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] idx_d;

    assign next_idx_o = win ? cnt_i : idx_q;

    // Index of the earliest maximum seen so far
    always_comb begin
        idx_d = idx_q;
        if (start_i) begin
            idx_d = '0;
        end else if (accept_i) begin
            idx_d = next_idx_o;
        end
    end

    // Index register
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt_i;
`endif

endmodule

// File: rtl/maxpool_window.sv
// Streaming max-pool over WIN beats on LANES parallel channels with a
// ready/valid handshake and a single registered output stage.
// Optional feature macro: MAXPOOL_ARGMAX_EN (adds out_idx).
module maxpool_window
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned WIN    = 4,
    parameter int unsigned LANES  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data
`ifdef MAXPOOL_ARGMAX_EN
    ,
    output logic [LANES*idx_width(WIN)-1:0] out_idx
`endif
);

    localparam int unsigned      CNT_W = idx_width(WIN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIN - 1);

    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    out_valid_q;
    logic                    out_valid_d;
    logic [LANES*DATA_W-1:0] out_data_q;
    logic [LANES*DATA_W-1:0] out_data_d;
    logic [LANES*DATA_W-1:0] next_data;
    logic                    beat_acc;
    logic                    final_beat;
    logic                    lane_start;

    // No skid buffer: a new beat only enters when the output slot frees up
    assign in_ready   = !out_valid_q || out_ready;
    assign beat_acc   = in_valid && in_ready && !clr;
    assign final_beat = beat_acc && (cnt_q == LAST);
    assign lane_start = clr || final_beat;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef MAXPOOL_ARGMAX_EN
    logic [LANES*CNT_W-1:0] out_idx_q;
    logic [LANES*CNT_W-1:0] out_idx_d;
    logic [LANES*CNT_W-1:0] next_idx;

    assign out_idx = out_idx_q;
`endif

    // Per-lane accumulators
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        maxpool_lane #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .start_i    (lane_start),
            .accept_i   (beat_acc),
            .x_i        (in_data[l*DATA_W +: DATA_W]),
            .cnt_i      (cnt_q),
            .next_o     (next_data[l*DATA_W +: DATA_W])
`ifdef MAXPOOL_ARGMAX_EN
            ,
            .next_idx_o (next_idx[l*CNT_W +: CNT_W])
`endif
        );
    end

    // Beat counter and output stage next state; a final beat overrides a drain
    always_comb begin
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef MAXPOOL_ARGMAX_EN
        out_idx_d   = out_idx_q;
`endif
        if (clr) begin
            cnt_d = '0;
        end else if (beat_acc) begin
            cnt_d = final_beat ? '0 : cnt_q + CNT_W'(1);
        end

        if (final_beat) begin
            out_valid_d = 1'b1;
            out_data_d  = next_data;
`ifdef MAXPOOL_ARGMAX_EN
            out_idx_d   = next_idx;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef MAXPOOL_ARGMAX_EN
            out_idx_q   <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef MAXPOOL_ARGMAX_EN
            out_idx_q   <= out_idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_maxpool_window.sv
// Scoreboard bench for maxpool_window (DATA_W=32, WIN=4, LANES=2).
module tb_maxpool_window;

    typedef struct {
        logic [63:0] d;
        logic [3:0]  i;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
`ifdef MAXPOOL_ARGMAX_EN
    logic [3:0]  out_idx;
`endif

    int   total = 0;
    int   bad   = 0;
    int   n_out = 0;
    exp_t sb[$];

    maxpool_window #(
        .DATA_W (32),
        .WIN    (4),
        .LANES  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef MAXPOOL_ARGMAX_EN
        ,
        .out_idx   (out_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] l0, input logic [31:0] l1,
                        input logic [1:0] i0, input logic [1:0] i1);
        exp_t e;
        e.d = {l1, l0};
        e.i = {i1, i0};
        sb.push_back(e);
    endtask

    // Present one beat and return #1 after the edge that accepted it
    task automatic beat(input logic [31:0] l0, input logic [31:0] l1);
        int   n;
        logic acc;
        in_valid = 1'b1;
        in_data  = {l1, l0};
        n = 0;
        forever begin
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                check("beat_timeout", 64'd1, 64'd0);
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = 'x;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every output handshake pops and compares the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {32'd0, out_data[31:0]}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("out_data", out_data, e.d);
`ifdef MAXPOOL_ARGMAX_EN
                check("out_idx", {60'd0, out_idx}, {60'd0, e.i});
`endif
                n_out++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        idle(2);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;
        idle(1);

        // Basic window
        push(32'd17, 32'd0, 2'd2, 2'd0);
        beat(32'd5, -32'sd1);
        beat(-32'sd3, -32'sd8);
        beat(32'd17, -32'sd2);
        beat(32'd2, -32'sd9);
        check("t1_latency", {63'd0, out_valid}, 64'd1);
        idle(1);
        check("t1_single_pulse", {63'd0, out_valid}, 64'd0);

        // Back-to-back windows, no bubbles
        push(32'd4, 32'd4, 2'd3, 2'd3);
        push(32'd8, 32'd8, 2'd3, 2'd3);
        for (int i = 1; i <= 8; i++) begin
            check("t2_in_ready", {63'd0, in_ready}, 64'd1);
            beat(32'(i), 32'(i));
            check("t2_out_valid", {63'd0, out_valid}, {63'd0, (i % 4) == 0});
        end
        idle(1);

        // Backpressure: result held, beat stalls, nothing lost on resume
        out_ready = 1'b0;
        push(32'd4, 32'd4, 2'd3, 2'd3);
        for (int i = 1; i <= 4; i++) beat(32'(i), 32'(i));
        check("t3_valid", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b1;
        in_data  = {32'd9, 32'd9};
        for (int i = 0; i < 10; i++) begin
            check("t3_in_ready_low", {63'd0, in_ready}, 64'd0);
            check("t3_hold", out_data, {32'd4, 32'd4});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        push(32'd9, 32'd9, 2'd0, 2'd0);
        beat(32'd9, 32'd9);
        beat(32'd1, 32'd1);
        beat(32'd2, 32'd2);
        beat(32'd3, 32'd3);
        idle(1);

        // Ties keep the earliest; max positive beats min negative
        push(32'd9, 32'h7FFFFFFF, 2'd0, 2'd1);
        beat(32'd9, 32'h80000000);
        beat(32'd9, 32'h7FFFFFFF);
        beat(32'd3, 32'd0);
        beat(32'd9, 32'h80000000);
        idle(1);

        // clr drops the partial window and the beat presented with it
        beat(32'd100, 32'd100);
        beat(32'd50, 32'd50);
        in_valid = 1'b1;
        clr      = 1'b1;
        in_data  = {32'd200, 32'd200};
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        check("t5_no_out", {63'd0, out_valid}, 64'd0);
        push(32'd4, 32'd4, 2'd3, 2'd3);
        for (int i = 1; i <= 4; i++) beat(32'(i), 32'(i));
        idle(1);

        // Reset with a pending result, then with a partial window
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(32'd33, 32'd44);
        check("t6_pending", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("t6_rst_valid", {63'd0, out_valid}, 64'd0);
        check("t6_rst_data", out_data, 64'd0);
`ifdef MAXPOOL_ARGMAX_EN
        check("t6_rst_idx", {60'd0, out_idx}, 64'd0);
`endif
        beat(32'd90, 32'd90);
        beat(32'd90, 32'd90);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        out_ready = 1'b1;
        push(32'd7, 32'd7, 2'd0, 2'd0);
        for (int i = 1; i <= 4; i++) begin
            beat(32'd7, 32'd7);
            check("t6_count", {63'd0, out_valid}, {63'd0, i == 4});
        end
        idle(3);

        check("sb_empty", 64'(sb.size()), 64'd0);
        check("n_out", 64'(n_out), 64'd8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
